// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the two-port memory arbiter.
// Port 0 is instruction fetch, port 1 is load/store.
package mem_arbiter_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned PORT_IF   = 0;
    localparam int unsigned PORT_LS   = 1;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 32;

    typedef logic [NUM_PORTS-1:0] port_mask_t;

    // One-hot mask selecting a single port by its index.
    function automatic port_mask_t port_onehot(input logic idx);
        return idx ? port_mask_t'(2'b10) : port_mask_t'(2'b01);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response channels of both ports plus the single-port memory bus.
// slave = arbiter side, master = requesters and memory side.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;

    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [2*DW-1:0] rsp_rdata;

    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with its last-grant register.
// Ties go to the port that was not granted most recently.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  port_mask_t i_elig,
    output port_mask_t o_grant
);
    logic       r_last_grant;
    port_mask_t w_grant;

    always_comb begin
        w_grant = '0;
        if (!rst) begin
            case (i_elig)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = port_onehot(~r_last_grant);
                default: w_grant = '0;
            endcase
        end
    end

    // Reset value 1 makes port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (|w_grant) begin
            r_last_grant <= w_grant[PORT_LS];
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between fetch and load/store ports.
// The granted request drives the memory combinationally; the response registers on the next edge.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    logic [AW-1:0]   w_addr      [NUM_PORTS];
    logic [DW-1:0]   w_wdata     [NUM_PORTS];
    port_mask_t      w_elig;
    port_mask_t      w_grant;
    logic            w_any_grant;
    logic            w_sel;

    logic            r_rsp_valid [NUM_PORTS];
    logic [DW-1:0]   r_rsp_rdata [NUM_PORTS];
    logic [1:0]      w_rsp_valid;
    logic [2*DW-1:0] w_rsp_rdata;

    // A port holding an undrained response may not issue; draining frees it the same cycle.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign w_addr[gi]  = bus.req_addr[gi*AW +: AW];
        assign w_wdata[gi] = bus.req_wdata[gi*DW +: DW];
        assign w_elig[gi]  = bus.req_valid[gi] && (!r_rsp_valid[gi] || bus.rsp_ready[gi]);
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .i_elig  (w_elig),
        .o_grant (w_grant)
    );

    assign w_any_grant = |w_grant;
    assign w_sel       = w_grant[PORT_LS];

    assign bus.req_ready = w_grant;
    assign bus.mem_we    = w_any_grant && bus.req_we[w_sel];
    assign bus.mem_addr  = w_any_grant ? w_addr[w_sel]  : '0;
    assign bus.mem_wdata = w_any_grant ? w_wdata[w_sel] : '0;

    // Memory writes on the falling edge and reads combinationally, so mem_rdata is final here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst) begin
                r_rsp_valid[i] <= 1'b0;
                r_rsp_rdata[i] <= '0;
            end else if (w_grant[i]) begin
                r_rsp_valid[i] <= 1'b1;
                r_rsp_rdata[i] <= bus.req_we[i] ? '0 : bus.mem_rdata;
            end else if (bus.rsp_ready[i]) begin
                r_rsp_valid[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        w_rsp_rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_rsp_valid[i]           = r_rsp_valid[i];
            w_rsp_rdata[i*DW +: DW] = r_rsp_rdata[i];
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = w_rsp_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word memory (8-bit word address, 32-bit data) between two requesters: port 0 is instruction fetch, port 1 is load/store.
- Per-port valid/ready request channel and registered response channel; round-robin fairness between ports.
- Drives the memory's write-enable, address and write-data, and captures its read data.
- The memory writes on the falling clock edge and reads combinationally. The arbiter therefore presents the granted request combinationally in the same cycle and registers the result at the next rising edge.

Parameters:
- AW, 8, word address width (memory depth 2^AW words)
- DW, 32, data width

Ports:
- clk  input  1  single clock; all arbiter state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  request valid per port (bit i = port i)
- req_ready  output  2  request accepted this cycle (one-hot or zero)
- req_we  input  2  1 = write, 0 = read, per port
- req_addr  input  2*AW  word address; port i at [i*AW +: AW]
- req_wdata  input  2*DW  write data; port i at [i*DW +: DW]
- rsp_valid  output  2  response valid per port
- rsp_ready  input  2  requester accepts response
- rsp_rdata  output  2*DW  read data per port; 0 for write acknowledgements
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data (combinational from mem_addr)

Behaviour:
- Eligibility: port i is eligible when req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). This lets a port issue back-to-back requests while its previous response drains. A port holding an unaccepted response is stalled; the other port is unaffected.
- Grant (combinational):
  - One eligible port: that port is granted.
  - Both eligible: the port other than last_grant is granted.
  - No eligible port: no grant.
  - req_ready = grant one-hot.
  - During rst, grant is forced to 0.
- Memory drive:
  - mem_addr = granted port's address, else 0.
  - mem_wdata = granted port's wdata, else 0.
  - mem_we = grant && granted req_we.
  - These signals are stable from the rising edge through the falling edge, so the write lands in the grant cycle.
- Response (rising edge after grant to port i):
  - rsp_valid[i] <= 1.
  - For a read: rsp_rdata[i] <= mem_rdata.
  - For a write: rsp_rdata[i] <= 0.
- Response hold:
  - If port i is not granted and rsp_ready[i] = 1: rsp_valid[i] <= 0.
  - Otherwise rsp_valid[i] and rsp_rdata[i] hold.
- Latency: request accepted in cycle N; response visible in cycle N+1. Sustained throughput is 1 access per cycle across both ports.
- Round-robin state:
  - last_grant (1 bit) updates to the granted port on any grant.
  - Reset value is 1, so port 0 wins the first tie.
- Read-after-write: a port-1 write in cycle N followed by a port-0 read of the same address in cycle N+1 returns the new data. The write completed at the falling edge of cycle N.
- Reset: synchronous.
  - rsp_valid = 0, rsp_rdata = 0, last_grant = 1.
  - req_ready = 0 and mem_we = 0 while rst is high.
  - An in-flight response is discarded; an uncompleted request must be reissued.
- The combinational path req inputs -> mem_addr -> mem_rdata -> response register is expected and allowed.

Decomposition:
- Shared package: port index constants (PORT_IF = 0, PORT_LS = 1) and the default AW/DW values.
- One sub-module is natural: rr_arb2, the 2-way round-robin grant logic plus last_grant register. The rest is flat.

Test Plan:
- Port 1 writes 0xDEADBEEF to addr 0x10; next cycle port 0 reads 0x10 -> port 1 gets rsp_valid with rdata 0 in cycle 1; port 0 gets rsp_rdata 0xDEADBEEF in cycle 2.
- Both ports request reads of different addresses continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each port gets a response every other cycle with correct data.
- Port 0 holds rsp_ready = 0 for 3 cycles with a new request pending -> port 0 is never granted; port 1 is granted every cycle; port 0's rsp_rdata stays constant; port 0 is granted the cycle rsp_ready rises.
- Port 0 streams reads at addrs 0..3 with rsp_ready = 1 and port 1 idle -> 4 grants in 4 consecutive cycles; responses in cycles 1..4 in order.
- rst asserted in the same cycle as a port-1 write request to addr 0x20, which was preloaded with 0x5 -> req_ready = 0, mem_we = 0; a later read of 0x20 returns 0x5; all rsp_valid are 0 after reset.
- Write to 0xFF, the top address, then read it back -> correct data, no aliasing to 0x00.
